// File: rtl/omp_pixel_sink_pkg.sv
// Shared constants and read-FSM encoding for the pixel sink and its helpers.
package omp_pixel_sink_pkg;

    localparam int PIX_PER_BLK = 64;
    localparam int PIX_ADDR_W  = 6;
    localparam int PIX_VAL_W   = 24;
    localparam int PIX_OUT_W   = 8;

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_FETCH   = 2'd1,
        R_STREAM  = 2'd2,
        R_RELEASE = 2'd3
    } rd_state_e;

endpackage

// File: rtl/omp_pixel_sink_pixel_sat_round.sv
// Signed fixed-point coefficient to unsigned 8-bit pixel: round half-up, then clamp to 0..255.
module pixel_sat_round
    import omp_pixel_sink_pkg::*;
#(
    parameter int FRAC_BITS = 12
) (
    input  logic [PIX_VAL_W-1:0] v,
    output logic [PIX_OUT_W-1:0] pix
);

    // One extra bit of headroom so adding the half-LSB can never wrap.
    localparam logic signed [PIX_VAL_W:0] HALF    = 25'sd1 <<< (FRAC_BITS - 1);
    localparam logic signed [PIX_VAL_W:0] PIX_MAX = 25'sd255;
    localparam logic signed [PIX_VAL_W:0] ZERO    = 25'sd0;

    logic signed [PIX_VAL_W:0] v_ext;
    logic signed [PIX_VAL_W:0] sum;
    logic signed [PIX_VAL_W:0] t;

    always_comb begin
        v_ext = signed'({v[PIX_VAL_W-1], v});
        sum   = v_ext + HALF;
        t     = sum >>> FRAC_BITS;
        if (t < ZERO) begin
            pix = '0;
        end else if (t > PIX_MAX) begin
            pix = '1;
        end else begin
            pix = t[PIX_OUT_W-1:0];
        end
    end

endmodule

// File: rtl/omp_pixel_sink.sv
// Ping-pong pixel block sink: collects 64 coefficients per bank, then drains them as 8-bit pixels.
module omp_pixel_sink
    import omp_pixel_sink_pkg::*;
#(
    parameter int FRAC_BITS = 12,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PIX_ADDR_W-1:0] pixel_addr,
    input  logic [PIX_VAL_W-1:0]  pixel_val,
    input  logic                  pixel_we,
    input  logic                  block_c_done,
    output logic                  sink_ready,
    output logic [PIX_OUT_W-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [CNT_W-1:0]      out_blk_cnt,
    output logic                  overflow,
    output logic [1:0]            rd_state_dbg
);

    // Output handshake: a pixel transfers on any rising edge where out_valid && out_ready;
    // while out_valid && !out_ready, out_data/out_last/out_valid do not change.

    localparam logic [PIX_ADDR_W-1:0] LAST_PIX = PIX_ADDR_W'(PIX_PER_BLK - 1);

    logic [PIX_VAL_W-1:0]  mem [0:2*PIX_PER_BLK-1];
    logic [PIX_VAL_W-1:0]  rdata;
    logic [PIX_OUT_W-1:0]  conv_pix;
    logic [1:0]            bank_full, bank_full_nxt;
    logic                  wr_sel, rd_sel;
    rd_state_e             rd_state, rd_state_nxt;
    logic [PIX_ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic                  wr_free, wr_ok, done_ok, fetch, release_blk, hs, last_pix;

    assign wr_free      = ~bank_full[wr_sel];
    assign wr_ok        = pixel_we & wr_free;
    assign done_ok      = block_c_done & wr_free;
    assign sink_ready   = wr_free;
    assign fetch        = (rd_state == R_FETCH);
    assign release_blk  = (rd_state == R_RELEASE);
    assign out_valid    = (rd_state == R_STREAM);
    assign hs           = out_valid & out_ready;
    assign last_pix     = (rd_ptr == LAST_PIX);
    assign out_last     = out_valid & last_pix;
    assign out_data     = out_valid ? conv_pix : '0;
    assign rd_state_dbg = rd_state;

    // Simple-dual-port RAM: bank select is the address MSB; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[{wr_sel, pixel_addr}] <= pixel_val;
        end
        if (fetch) begin
            rdata <= mem[{rd_sel, rd_ptr}];
        end
    end

    pixel_sat_round #(.FRAC_BITS(FRAC_BITS)) u_conv (
        .v   (rdata),
        .pix (conv_pix)
    );

    always_comb begin
        rd_state_nxt = rd_state;
        rd_ptr_nxt   = rd_ptr;
        case (rd_state)
            R_IDLE: begin
                if (bank_full[rd_sel]) begin
                    rd_state_nxt = R_FETCH;
                    rd_ptr_nxt   = '0;
                end
            end
            R_FETCH:  rd_state_nxt = R_STREAM;
            R_STREAM: begin
                if (hs) begin
                    if (last_pix) begin
                        rd_state_nxt = R_RELEASE;
                    end else begin
                        rd_state_nxt = R_FETCH;
                        rd_ptr_nxt   = rd_ptr + 1'b1;
                    end
                end
            end
            R_RELEASE: rd_state_nxt = R_IDLE;
            default:   rd_state_nxt = R_IDLE;
        endcase
    end

    // Set (write side) and clear (read side) always address different banks, so both apply.
    always_comb begin
        bank_full_nxt = bank_full;
        if (release_blk) begin
            bank_full_nxt[rd_sel] = 1'b0;
        end
        if (done_ok) begin
            bank_full_nxt[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state    <= R_IDLE;
            rd_ptr      <= '0;
            bank_full   <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            overflow    <= 1'b0;
            out_blk_cnt <= '0;
        end else begin
            rd_state  <= rd_state_nxt;
            rd_ptr    <= rd_ptr_nxt;
            bank_full <= bank_full_nxt;
            if (done_ok) begin
                wr_sel <= ~wr_sel;
            end
            if (release_blk) begin
                rd_sel      <= ~rd_sel;
                out_blk_cnt <= out_blk_cnt + 1'b1;
            end
            if ((pixel_we | block_c_done) & ~wr_free) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_omp_pixel_sink.sv
// Directed bench for omp_pixel_sink (FRAC_BITS=12): conversion table, backpressure, ping-pong, reset.
module tb_omp_pixel_sink;
    import omp_pixel_sink_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  pixel_addr = '0;
    logic [23:0] pixel_val = '0;
    logic        pixel_we = 1'b0;
    logic        block_c_done = 1'b0;
    logic        sink_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [15:0] out_blk_cnt;
    logic        overflow;
    logic [1:0]  rd_state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int exp_blk = 0;
    logic [8:0] exp_q[$];

    logic [23:0] rnd_val [10] = '{24'h064800, 24'h0647FF, 24'hFFF000, 24'h200000, 24'h7FFFFF,
                                  24'hFFF800, 24'h000800, 24'h0FF7FF, 24'h0FF800, 24'h800000};
    logic [7:0]  rnd_exp [10] = '{8'd101, 8'd100, 8'd0, 8'd255, 8'd255,
                                  8'd0,   8'd1,   8'd255, 8'd255, 8'd0};

    omp_pixel_sink #(.FRAC_BITS(12), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_addr   (pixel_addr),
        .pixel_val    (pixel_val),
        .pixel_we     (pixel_we),
        .block_c_done (block_c_done),
        .sink_ready   (sink_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_blk_cnt  (out_blk_cnt),
        .overflow     (overflow),
        .rd_state_dbg (rd_state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks: each starts and ends 1 ns after a rising edge
    task automatic wr(input logic [5:0] a, input logic [23:0] v, input logic done);
        pixel_addr   = a;
        pixel_val    = v;
        pixel_we     = 1'b1;
        block_c_done = done;
        @(posedge clk); #1;
        pixel_we     = 1'b0;
        block_c_done = 1'b0;
    endtask

    task automatic pulse_done();
        block_c_done = 1'b1;
        @(posedge clk); #1;
        block_c_done = 1'b0;
    endtask

    task automatic push_exp(input logic [5:0] a, input logic [7:0] d);
        exp_q.push_back({(a == 6'd63), d});
    endtask

    // scoreboard consumer: mode 0 = always ready, mode 1 = random ready with a 20-cycle stall at pixel 5
    task automatic drain(input int mode, input int npix);
        int got = 0;
        int cyc = 0;
        int stall = 0;
        logic [8:0] e;
        while (got < npix && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (mode == 1) begin
                if (got == 5 && out_valid && stall < 20) begin
                    out_ready = 1'b0;
                    stall++;
                    chk("hold_valid", out_valid, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        chk("hold_data", out_data, e[7:0]);
                        chk("hold_last", out_last, e[8]);
                    end
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pix", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_data", out_data, e[7:0]);
                    chk("pix_last", out_last, e[8]);
                end
                got++;
            end
        end
        if (got < npix) chk("drain_timeout", got, npix);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int k;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sink_ready", sink_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_blk_cnt", out_blk_cnt, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_state", rd_state_dbg, R_IDLE);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single block, integer values, with done-to-valid latency
        for (int i = 0; i < 64; i++) begin
            wr(6'(i), 24'(i << 12), 1'b0);
            push_exp(6'(i), 8'(i));
        end
        pulse_done();
        chk("single_ready_after_done", sink_ready, 1);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (out_valid) seen = 1'b1;
        end
        chk("latency_le3", (seen && k <= 3), 1);
        drain(0, 64);
        repeat (2) @(posedge clk);
        #1;
        exp_blk = 1;
        chk("single_blk_cnt", out_blk_cnt, exp_blk);
        chk("single_sink_ready", sink_ready, 1);
        chk("single_overflow", overflow, 0);

        // rounding and saturation table in pixels 0..9
        for (int i = 0; i < 64; i++) begin
            if (i < 10) begin
                wr(6'(i), rnd_val[i], 1'b0);
                push_exp(6'(i), rnd_exp[i]);
            end else begin
                wr(6'(i), 24'(i << 12), 1'b0);
                push_exp(6'(i), 8'(i));
            end
        end
        pulse_done();
        drain(0, 64);
        repeat (2) @(posedge clk);
        #1;
        exp_blk = 2;
        chk("round_blk_cnt", out_blk_cnt, exp_blk);

        // backpressure: value i + 0.4998 rounds down to i
        for (int i = 0; i < 64; i++) begin
            wr(6'(i), 24'((i << 12) | 32'h7FF), 1'b0);
            push_exp(6'(i), 8'(i));
        end
        pulse_done();
        drain(1, 64);
        repeat (2) @(posedge clk);
        #1;
        exp_blk = 3;
        chk("bp_blk_cnt", out_blk_cnt, exp_blk);

        // ping-pong: A stalls in the read side while B fills, then a dropped write
        for (int i = 0; i < 64; i++) begin
            wr(6'(i), 24'((i + 100) << 12), 1'b0);
            push_exp(6'(i), 8'(i + 100));
        end
        pulse_done();
        chk("pp_ready_after_a", sink_ready, 1);
        for (int i = 0; i < 64; i++) begin
            wr(6'(i), 24'((200 - i) << 12), 1'b0);
            push_exp(6'(i), 8'(200 - i));
        end
        pulse_done();
        chk("pp_ready_after_b", sink_ready, 0);
        chk("pp_overflow_before", overflow, 0);
        wr(6'd10, 24'h001000, 1'b0);
        chk("pp_overflow_set", overflow, 1);
        chk("pp_ready_still_low", sink_ready, 0);
        drain(0, 128);
        repeat (2) @(posedge clk);
        #1;
        exp_blk = 5;
        chk("pp_blk_cnt", out_blk_cnt, exp_blk);
        chk("pp_ready_end", sink_ready, 1);
        chk("pp_overflow_sticky", overflow, 1);

        // same-cycle write+done at pixel 63, then the next block in the other bank
        for (int i = 0; i < 63; i++) begin
            wr(6'(i), 24'((i << 12) | 32'h800), 1'b0);
            push_exp(6'(i), 8'(i + 1));
        end
        wr(6'd63, 24'h0FF000, 1'b1);
        push_exp(6'd63, 8'd255);
        chk("sc_ready_after_c", sink_ready, 1);
        for (int i = 0; i < 64; i++) begin
            wr(6'(i), 24'((3 * i) << 12), 1'b0);
            push_exp(6'(i), 8'(3 * i));
        end
        pulse_done();
        chk("sc_ready_after_d", sink_ready, 0);
        drain(0, 128);
        repeat (2) @(posedge clk);
        #1;
        exp_blk = 7;
        chk("sc_blk_cnt", out_blk_cnt, exp_blk);

        // asynchronous reset in the middle of a block
        for (int i = 0; i < 64; i++) begin
            wr(6'(i), 24'(i << 12), 1'b0);
            push_exp(6'(i), 8'(i));
        end
        pulse_done();
        drain(0, 30);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_blk_cnt", out_blk_cnt, 0);
        chk("arst_sink_ready", sink_ready, 1);
        chk("arst_overflow", overflow, 0);
        chk("arst_state", rd_state_dbg, R_IDLE);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("arst_quiet", out_valid, 0);
        end
        out_ready = 1'b0;
        @(posedge clk); #1;

        // recovery block after reset
        for (int i = 0; i < 64; i++) begin
            wr(6'(i), 24'((63 - i) << 12), 1'b0);
            push_exp(6'(i), 8'(63 - i));
        end
        pulse_done();
        drain(0, 64);
        repeat (2) @(posedge clk);
        #1;
        exp_blk = 1;
        chk("recover_blk_cnt", out_blk_cnt, exp_blk);
        chk("recover_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/omp_pixel_sink.md
Name: omp_pixel_sink

Overview:
- Receiving end of the reconstruction core's pixel write stream (pixel_addr/pixel_val/pixel_we, block_c_done).
- Collects one 64-pixel block of signed fixed-point coefficients into a ping-pong buffer.
- Converts each coefficient to an unsigned 8-bit pixel by rounding and saturation.
- Streams the block out in raster order over a valid/ready byte interface, so the next reconstruction can overlap the drain of the previous one.

Parameters:
- FRAC_BITS, 12, fractional bits of the incoming 24-bit signed pixel value (range 1..22).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- pixel_addr  input  6  pixel index 0..63 within the block, raster order
- pixel_val  input  24  signed coefficient, Q(23-FRAC_BITS).FRAC_BITS
- pixel_we  input  1  write strobe for pixel_addr/pixel_val
- block_c_done  input  1  one-cycle pulse: current block complete
- sink_ready  output  1  a write bank is free; the top level must not pulse start_c while low
- out_data  output  8  converted pixel
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_last  output  1  high with pixel 63 of a block
- out_blk_cnt  output  CNT_W  number of blocks fully drained; wraps modulo 2^CNT_W
- overflow  output  1  sticky: a write or done was dropped because no bank was free

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: sink_ready=1, out_valid=0, out_last=0, out_data=0, out_blk_cnt=0, overflow=0. Both banks FREE, wr_sel=0, rd_sel=0, read FSM in R_IDLE. Memory contents are not reset.
- Reset mid-operation discards both banks and any partially streamed block.
- Storage: two banks of 64x24. Each bank has status FREE or FULL (2-bit bank_full vector).
- Write side:
  - pixel_we with bank[wr_sel] FREE writes pixel_val at pixel_addr in the same cycle.
  - A pixel address written twice keeps the last value.
  - A pixel not written in a block keeps stale contents; no clearing is performed.
  - block_c_done with bank[wr_sel] FREE sets bank[wr_sel] FULL and toggles wr_sel on the next edge.
  - pixel_we and block_c_done in the same cycle: the write lands in the old wr_sel bank before the swap.
- Overflow: pixel_we or block_c_done while bank[wr_sel] is FULL is dropped and sets overflow. Overflow clears only on reset.
- sink_ready = bank[wr_sel] FREE (combinational from registered state).
- Read FSM:
  - R_IDLE: if bank[rd_sel] FULL, go to R_FETCH with rd_ptr=0.
  - R_FETCH: synchronous memory read of bank[rd_sel][rd_ptr]; 1-cycle latency; go to R_STREAM next cycle.
  - R_STREAM:
    - Load out_data = convert(rdata) and assert out_valid.
    - On an out_valid && out_ready handshake: if rd_ptr==63 go to R_RELEASE; else increment rd_ptr and return to R_FETCH.
    - One bubble cycle per pixel is permitted; throughput is 1 pixel per 2 cycles minimum.
    - out_data, out_last and out_valid hold stable while out_valid && !out_ready.
  - R_RELEASE: out_valid=0, bank[rd_sel] set FREE, rd_sel toggles, out_blk_cnt increments, back to R_IDLE.
- out_last = out_valid && rd_ptr==63.
- Same-cycle set and clear of bank_full: done (set) on one bank and release (clear) on the other are independent. Both take effect.
- Conversion, on the 24-bit signed value v:
  - t = (v + 2^(FRAC_BITS-1)) >>> FRAC_BITS, computed in 25 bits so the add cannot overflow.
  - Saturate: t<0 gives 0; t>255 gives 255; otherwise t[7:0].
  - Rounding is half-up toward +inf.
- Latency: from block_c_done to first out_valid is at most 3 cycles when the read side is idle.

Decomposition:
- Shared package: PIX_PER_BLK=64, PIX_ADDR_W=6, PIX_VAL_W=24, read FSM state encodings.
- Sub-module pixel_sat_round: combinational convert() parameterised by FRAC_BITS, reusable by other output paths.
- Banks inferred as a single 128x24 simple-dual-port RAM addressed by {bank, pixel_addr}.

Test Plan (FRAC_BITS=12):
- Single block: 64 writes with pixel_val=addr<<12, then done, out_ready=1 -> out_data 0..63 in order, out_last only on 63, out_blk_cnt 0->1, sink_ready stays 1.
- Rounding/saturation: 0x064800 -> 101; 0x0647FF -> 100; 0xFFF000 (-1.0) -> 0; 0x200000 (512.0) -> 255; 0x7FFFFF -> 255.
- Backpressure: out_ready toggled randomly, held low 20 cycles at pixel 5 -> out_data/out_valid stable throughout, no pixel lost or duplicated.
- Ping-pong: block A done, block B written and done while A drains with out_ready=0 -> sink_ready falls after B's done; a third pixel_we sets overflow, A then B drain intact.
- Same-cycle we+done at addr 63 value 0x0FF000 -> pixel 63 of that block outputs 255, the next block starts in the other bank.
- Async reset asserted mid-stream at pixel 30 -> outputs return to reset values immediately, no further out_valid until a new block is done.
